// File: rtl/backward_slice.sv
// Backward register slice (skid buffer): in_rdy comes from a flop, and data passes through when no skid word is held.
// Optional stall statistics counter on the stall_cnt port, enabled by defining BACKWARD_SLICE_STATS_EN.
module backward_slice #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data
`ifdef BACKWARD_SLICE_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                in_rdy_q;
  logic                skid_vld;
  logic                capture;
  logic [DATA_W-1:0]   skid_data;

  assign skid_vld = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_vld && in_rdy_q && !out_rdy) begin
          state_d = FULL;
          capture = 1'b1;
        end
      end
      FULL: begin
        if (out_rdy) begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  // in_rdy is a separate flop loaded from the next state, so it has no same-cycle path from out_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      in_rdy_q  <= 1'b1;
      skid_data <= '0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d == EMPTY);
      if (capture) begin
        skid_data <= in_data;
      end
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = skid_vld | in_vld;
  assign out_data = skid_vld ? skid_data : in_data;

`ifdef BACKWARD_SLICE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_vld && !out_rdy && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_backward_slice.sv
// Scoreboard bench for backward_slice: accepted words are queued and checked in order at the output.
module tb_backward_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [15:0] in_data = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;
`ifdef BACKWARD_SLICE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  backward_slice #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data)
`ifdef BACKWARD_SLICE_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  bit          model_full = 1'b0;
  int unsigned stall_exp = 0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data = '0;
  bit          rand_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_full = 1'b0;
    stall_exp  = 0;
    prev_hold  = 1'b0;
  endtask

  // Reference: one-word buffer; a word is taken when the buffer is empty, and the
  // presented word is always the oldest one not yet delivered.
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      ev = model_full | in_vld;
      chk("in_rdy", in_rdy, !model_full);
      chk("out_vld", out_vld, ev);
      if (prev_hold && out_vld) chk("hold_stable", out_data, prev_data);
`ifdef BACKWARD_SLICE_STATS_EN
      chk("stall_cnt", stall_cnt, stall_exp);
`endif
      if (in_vld && !model_full) exp_q.push_back(in_data);
      if (ev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_data: got %h expected no word at %0t", out_data, $time);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_rdy) void'(exp_q.pop_front());
        end
      end
      prev_hold = out_vld && !out_rdy;
      prev_data = out_data;
      if (ev && !out_rdy && stall_exp < 65535) stall_exp++;
      model_full = model_full ? !out_rdy : (in_vld && !out_rdy);
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1 out_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle();
    in_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] d);
    bit acc;
    int n;
    n = 0;
    in_vld  = 1'b1;
    in_data = d;
    forever begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout: word %h not accepted after %0d cycles", d, n);
        break;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: pass-through outputs while held in reset
    in_vld  = 1'b1;
    in_data = 16'hAAAA;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 1);
    chk("rst_out_data", out_data, 16'hAAAA);
`ifdef BACKWARD_SLICE_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    // Back-to-back pass-through
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) send(16'(i));
    idle();

    // Skid capture and hold
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 16'h1234;
    @(posedge clk); #1;
    in_data = 16'h5678;
    chk("skid_in_rdy", in_rdy, 0);
    chk("skid_out_vld", out_vld, 1);
    chk("skid_out_data", out_data, 16'h1234);
    @(posedge clk); #1;
    chk("skid_held", out_data, 16'h1234);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("skid_release_in_rdy", in_rdy, 1);
    chk("skid_release_out_vld", out_vld, 0);

    // Random backpressure, incrementing payload
    rand_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(16'h0100 + 16'(i));
    end
    in_vld  = 1'b0;
    rand_en = 1'b0;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    repeat (3) idle();
    chk("random_drain", exp_q.size(), 0);

    // Reset while a word is held in the skid
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 16'hBEEF;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("beef_held", out_data, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("midrst_in_rdy", in_rdy, 1);
    chk("midrst_out_vld", out_vld, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(16'hC000 + 16'(i));
    repeat (2) idle();
    chk("post_rst_drain", exp_q.size(), 0);

`ifdef BACKWARD_SLICE_STATS_EN
    // Long stall to saturate the counter
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_data = 16'h5A5A;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("stall_rst", stall_cnt, 0);
    in_vld = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/backward_slice.md
# backward_slice

Backward register slice (skid buffer) for the 16-bit valid/ready streaming interface. It registers the ready path (`in_rdy` driven from a flop) so upstream timing is cut on backpressure, and it passes data through combinationally when no skid entry is held. It is the upstream-side companion to the forward slice in this codebase, which registers the valid/data path. Placing one of each in series gives a full register slice.

## Interface
- `DATA_W`, default 16: payload width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_vld` input 1: upstream data valid.
- `in_rdy` output 1: upstream ready. Driven directly from a flop, with no combinational path from `out_rdy`.
- `in_data` input DATA_W: upstream payload.
- `out_vld` output 1: downstream data valid.
- `out_rdy` input 1: downstream ready.
- `out_data` output DATA_W: downstream payload.
- `stall_cnt` output 16: stall statistics. Present only with `BACKWARD_SLICE_STATS_EN`; see Configuration.

## Operation
- Internal state: `skid_vld` (1 bit) and `skid_data` (DATA_W bits).
- `in_rdy` is a register holding `~skid_vld`; the two are always complementary.
- Two states:
  - EMPTY (`skid_vld=0`, `in_rdy=1`):
    - `out_vld = in_vld`, `out_data = in_data` (pass-through).
  - FULL (`skid_vld=1`, `in_rdy=0`):
    - `out_vld = 1`, `out_data = skid_data`.
    - `in_data` and `in_vld` are ignored.
- EMPTY to FULL: when `in_vld & in_rdy & ~out_rdy`, capture `in_data` into `skid_data`, set `skid_vld=1` and `in_rdy=0` next cycle.
- EMPTY stays EMPTY:
  - `in_vld & out_rdy`: word passes through in the same cycle.
  - `~in_vld`: idle.
- FULL to EMPTY: when `out_rdy`, the skid word is consumed; `skid_vld=0` and `in_rdy=1` next cycle.
- FULL stays FULL: when `~out_rdy`. `skid_data` is held stable and `out_vld` stays 1.
- Upstream is never accepted while FULL, so there is no simultaneous fill and drain. Capacity is exactly one stored word.
- Ordering is strict FIFO; no word is dropped or duplicated.
- `skid_data` loads only on the EMPTY to FULL transition. It needs no reset for correctness but is reset to 0.
- Protocol obligations:
  - Once `out_vld=1` with `out_rdy=0`, `out_data` must stay stable until the transfer.
  - The slice guarantees this in FULL.
  - In EMPTY it relies on upstream holding `in_data` stable while `in_vld` is high and unaccepted. Upstream accepts, so the word moves to the skid.

## Timing
- Reset (`rst_n=0`, asynchronous): `skid_vld=0`, `in_rdy=1`, `skid_data=0`, `stall_cnt=0`.
  - Outputs then follow EMPTY pass-through: `out_vld=in_vld`, `out_data=in_data`.
- Reset mid-operation discards any held skid word immediately. The word is lost, by design.
- Latency:
  - EMPTY: 0 cycles, combinational `in` to `out`.
  - Skid path: 1+ cycles, until `out_rdy`.
- Backpressure propagates to `in_rdy` one cycle after the cycle where a word is accepted with `out_rdy=0`.
- After `out_rdy` returns, `in_rdy` rises one cycle later.
- Sustained throughput is 1 word/cycle when `out_rdy=1`.
- Worst-case pattern is one bubble per FULL drain, on the upstream side only.
- No combinational path from `out_rdy` to `in_rdy`.
- Combinational paths `in_vld` to `out_vld` and `in_data` to `out_data` exist through the output mux.

## Configuration
- Macro: `BACKWARD_SLICE_STATS_EN`.
- Defined:
  - Adds the `stall_cnt` port.
  - The counter increments every cycle with `out_vld & ~out_rdy`.
  - It saturates at 16'hFFFF and resets to 0 on `rst_n` low.
  - It is not otherwise clearable.
- Undefined: the port and counter logic are absent. Datapath behaviour is identical either way.

## Test plan
- Reset check: hold `rst_n=0` with `in_vld=1`, `in_data=16'hAAAA` → `in_rdy=1`, `out_vld=1`, `out_data=16'hAAAA` combinationally; `stall_cnt=0`.
- Pass-through: `out_rdy=1`, send 0x0001..0x0010 back-to-back → same sequence on `out_data` in the same cycles; `in_rdy` stays 1.
- Skid capture: send 0x1234 with `out_rdy=0` →
  - next cycle: `in_rdy=0`, `out_vld=1`, `out_data=0x1234`;
  - changing `in_data` to 0x5678 has no effect;
  - raising `out_rdy` → 0x1234 transfers, then `in_rdy=1` the following cycle.
- Random backpressure: 1000 words, incrementing payload, `out_rdy` random at 50% → scoreboard sees all 1000 in order, no duplicates; `in_rdy` never depends on same-cycle `out_rdy`.
- Reset mid-FULL: hold 0xBEEF in skid with `out_rdy=0`, pulse `rst_n` low asynchronously mid-cycle → `in_rdy=1` and `skid_vld=0` immediately; 0xBEEF never appears after release.
- Stats (`BACKWARD_SLICE_STATS_EN`): hold `out_rdy=0` with `out_vld=1` for 70000 cycles → `stall_cnt` reads 16'hFFFF and stays there; after reset it reads 0.
